// File: rtl/stack_mem_resp.sv
// Data-memory responder for the calculator stack: 128x8 posedge RAM behind a
// registered req/ack handshake, with a sequential bulk-clear engine.
module stack_mem_resp #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          clr,
  output logic [DW-1:0] rdata,
  output logic          ack,
  output logic          busy
);

  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_CLEAR  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          ack_q, ack_d;

  logic          mem_wr_c;
  logic [AW-1:0] mem_waddr_c;
  logic [DW-1:0] mem_wdata_c;

  logic [DW-1:0] mem [DEPTH];

  // Next-state, request capture and RAM write-port steering
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    ack_d       = 1'b0;
    mem_wr_c    = 1'b0;
    mem_waddr_c = '0;
    mem_wdata_c = '0;

    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          cnt_d   = '0;
          state_d = ST_CLEAR;
        end else if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (we_q) begin
          mem_wr_c    = 1'b1;
          mem_waddr_c = addr_q;
          mem_wdata_c = wdata_q;
        end else begin
          rdata_d = mem[addr_q];
        end
        ack_d   = 1'b1;
        state_d = ST_IDLE;
      end

      ST_CLEAR: begin
        mem_wr_c    = 1'b1;
        mem_waddr_c = cnt_q;
        mem_wdata_c = '0;
        cnt_d       = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) begin
          ack_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
    end
  end

  // Array is not reset; a reset edge suppresses any in-flight write or clear step
  always_ff @(posedge clk) begin
    if (!rst && mem_wr_c) begin
      mem[mem_waddr_c] <= mem_wdata_c;
    end
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_stack_mem_resp.sv
// Randomized self-checking bench for stack_mem_resp against a transaction-level
// memory model (array contents plus last-read value).
module tb_stack_mem_resp;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 7;
  localparam int unsigned DEPTH = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          clr;
  logic [DW-1:0] rdata;
  logic          ack;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] model_rdata;

  always #5 clk = ~clk;

  stack_mem_resp #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .clr   (clr),
    .rdata (rdata),
    .ack   (ack),
    .busy  (busy)
  );

  task automatic chk_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle past it before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    req = 1'b0;
    clr = 1'b0;
    repeat (n) begin
      tick();
      chk_eq("idle_ack", ack, 0);
      chk_eq("idle_busy", busy, 0);
      chk_eq("idle_rdata", rdata, model_rdata);
    end
  endtask

  // One access: accept edge, then completion edge; inject drives a stray write
  // request while the responder is busy, which must be ignored.
  task automatic access(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit inject);
    req   = 1'b1;
    clr   = 1'b0;
    we    = w;
    addr  = a;
    wdata = d;
    tick();
    chk_eq("acc_busy", busy, 1);
    chk_eq("acc_ack_early", ack, 0);
    if (inject) begin
      we    = 1'b1;
      addr  = 7'h10;
      wdata = 8'hFF;
    end
    tick();
    if (w) model_mem[a] = d;
    else   model_rdata  = model_mem[a];
    chk_eq("acc_ack", ack, 1);
    chk_eq("acc_busy_done", busy, 0);
    chk_eq("acc_rdata", rdata, model_rdata);
    req = 1'b0;
  endtask

  task automatic clear(input bit with_req);
    clr   = 1'b1;
    req   = with_req;
    we    = 1'b1;
    addr  = '0;
    wdata = 8'h99;
    tick();
    chk_eq("clr_start_busy", busy, 1);
    chk_eq("clr_start_ack", ack, 0);
    clr = 1'b0;
    req = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      tick();
      chk_eq("clr_busy", busy, 1);
      chk_eq("clr_ack", ack, 0);
    end
    tick();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    chk_eq("clr_done_ack", ack, 1);
    chk_eq("clr_done_busy", busy, 0);
    chk_eq("clr_rdata", rdata, model_rdata);
  endtask

  initial begin
    rst   = 1'b1;
    req   = 1'b0;
    clr   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    model_rdata = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state held while idle
    idle_cycles(10);

    // Array is not reset, so establish known contents first
    clear(1'b0);
    idle_cycles(1);

    // Write then read the top address
    access(1'b1, 7'h7F, 8'h5A, 1'b0);
    access(1'b0, 7'h7F, 8'h00, 1'b0);
    chk_eq("rd_7f", rdata, 8'h5A);
    idle_cycles(1);

    // Back-to-back with req held continuously
    access(1'b1, 7'h7E, 8'h03, 1'b0);
    access(1'b1, 7'h7D, 8'h04, 1'b0);
    access(1'b0, 7'h7E, 8'h00, 1'b0);
    chk_eq("b2b_rd_7e", rdata, 8'h03);
    access(1'b0, 7'h7D, 8'h00, 1'b0);
    chk_eq("b2b_rd_7d", rdata, 8'h04);
    idle_cycles(1);

    // Request while busy is dropped
    access(1'b1, 7'h20, 8'h33, 1'b1);
    idle_cycles(3);
    access(1'b0, 7'h10, 8'h00, 1'b0);
    chk_eq("ignored_rd_10", rdata, 8'h00);

    // Clear wins over a simultaneous request
    access(1'b1, 7'h00, 8'h11, 1'b0);
    access(1'b1, 7'h7F, 8'h22, 1'b0);
    clear(1'b1);
    access(1'b0, 7'h00, 8'h00, 1'b0);
    chk_eq("clr_rd_00", rdata, 8'h00);
    access(1'b0, 7'h7F, 8'h00, 1'b0);
    chk_eq("clr_rd_7f", rdata, 8'h00);
    idle_cycles(1);

    // Reset during an access discards the write
    access(1'b1, 7'h05, 8'h66, 1'b0);
    req   = 1'b1;
    we    = 1'b1;
    addr  = 7'h05;
    wdata = 8'h77;
    tick();
    chk_eq("rst_acc_busy", busy, 1);
    rst = 1'b1;
    req = 1'b0;
    tick();
    model_rdata = '0;
    chk_eq("rst_acc_ack", ack, 0);
    chk_eq("rst_acc_busy_after", busy, 0);
    chk_eq("rst_acc_rdata", rdata, 0);
    rst = 1'b0;
    idle_cycles(2);
    access(1'b0, 7'h05, 8'h00, 1'b0);
    chk_eq("rst_acc_rd_05", rdata, 8'h66);

    // Reset mid-clear at cnt == 64
    for (int i = 0; i < DEPTH; i++) access(1'b1, AW'(i), 8'hAA, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_eq("rst_clr_busy", busy, 1);
    repeat (64) tick();
    chk_eq("rst_clr_busy64", busy, 1);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 64; i++) model_mem[i] = '0;
    model_rdata = '0;
    chk_eq("rst_clr_ack", ack, 0);
    chk_eq("rst_clr_busy_after", busy, 0);
    chk_eq("rst_clr_rdata", rdata, 0);
    rst = 1'b0;
    idle_cycles(3);
    access(1'b0, 7'h3F, 8'h00, 1'b0);
    chk_eq("rst_clr_rd_3f", rdata, 8'h00);
    access(1'b0, 7'h40, 8'h00, 1'b0);
    chk_eq("rst_clr_rd_40", rdata, 8'hAA);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 2)       clear(r == 0);
      else if (r < 15) idle_cycles(int'($urandom_range(1, 3)));
      else             access(1'($urandom), AW'($urandom), DW'($urandom), 1'($urandom_range(0, 3) == 0));
    end
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stack_mem_resp.md
# stack_mem_resp

Responder side of the calculator's data-memory interface: a 128 x 8 synchronous RAM behind a registered request/acknowledge handshake, plus a bulk-clear sequencer. The stack controller (initiator) issues single reads and writes at a data address (the DAR) and gets a one-cycle `ack` back. Clear zeroes the whole stack region when the calculator is reset from the front panel. It replaces the ad-hoc `we`/negedge RAM with a fully posedge, handshaked slave.

## Interface
- `DW`, 8, data width in bits.
- `AW`, 7, address width in bits; depth is 2**AW, 128 words.
- `clk`  in  1  system clock; every register updates on the rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `req`  in  1  access request; sampled only when `busy`=0.
- `we`  in  1  write when 1, read when 0; qualified by `req`.
- `addr`  in  AW  word address.
- `wdata`  in  DW  write data.
- `clr`  in  1  bulk-clear request; sampled only when `busy`=0.
- `rdata`  out  DW  read data, registered.
- `ack`  out  1  one-cycle completion pulse, registered.
- `busy`  out  1  high while a transaction or clear is in progress.

## Operation
- State machine has three states: IDLE, ACCESS, CLEAR.
- **IDLE**
  - `busy`=0.
  - If `clr`=1 at an edge, clear the 7-bit counter `cnt` to 0 and go to CLEAR. `clr` has priority; a simultaneous `req` is dropped.
  - Otherwise, if `req`=1 at an edge, latch `we`, `addr` and `wdata` into `we_q`, `addr_q` and `wdata_q`, and go to ACCESS. This edge is the accept edge.
- **ACCESS** (exactly 1 cycle), `busy`=1.
  - If `we_q`=1: write `RAM[addr_q]` <= `wdata_q`. `rdata` is unchanged.
  - If `we_q`=0: `rdata` <= `RAM[addr_q]`.
  - `ack` <= 1, then go to IDLE.
- **CLEAR**, `busy`=1.
  - Each cycle: `RAM[cnt]` <= 0 and `cnt` <= `cnt`+1.
  - On the cycle where `cnt`=127: `ack` <= 1, then go to IDLE.
  - Exactly 128 writes, with no wrap past 127.
- `ack` is 0 in every cycle except the one following completion.
- `rdata` holds its value until the next read completes. Writes and clears never modify `rdata`.
- `req` or `clr` asserted while `busy`=1 is ignored, not queued. The initiator must hold or re-assert it after `busy` falls.
- Address arithmetic (SPR±1 and similar) belongs to the initiator. The responder never modifies `addr_q`; it is AW bits wide, and all 128 addresses are valid.
- No read-during-write hazard exists: only one access is ever in flight.
- **Reset**
  - State <= IDLE; `rdata`, `ack`, `busy`, `cnt`, `we_q`, `addr_q` and `wdata_q` <= 0.
  - RAM contents are not reset. `clr` is the only way to zero them.
- **Reset during CLEAR**: the clear aborts immediately. Words at or above the current `cnt` keep their old values, and no `ack` is issued.
- **Reset during ACCESS**: the pending write or read is discarded. The RAM and `rdata` stay at their pre-edge values (`rdata` is then forced to 0 by reset), and no `ack` is issued.

## Timing
- `busy` is combinational from state, i.e. state != IDLE.
- Single access, with accept at edge N:
  - `busy`=1 between edges N and N+1.
  - The RAM write or `rdata` update happens at edge N+1.
  - `ack`=1 between edges N+1 and N+2.
  - `busy` is already 0 during the `ack` cycle, so the next request can be accepted at edge N+1 (back-to-back).
- Read latency: `req` seen at edge N, `rdata` valid at N+1, coincident with `ack`.
- Maximum throughput is one access per 2 cycles.
- Write followed by read of the same address: the read, accepted at N+1, returns the new data at N+2.
- Clear accepted at edge N: `busy`=1 for 128 cycles, and `ack` is high between edges N+128 and N+129.
- RAM write and read are both on the posedge. Read data comes from the registered `rdata` only, never combinationally from the array.

## Test plan
- Reset then idle → `rdata`=0x00, `ack`=0, `busy`=0 for 10 cycles with `req`=`clr`=0.
- Write 0x5A to addr 0x7F, then read 0x7F → after the read `ack`, `rdata`=0x5A. Each `ack` is exactly 1 cycle wide and arrives 2 cycles after the request is presented.
- Back-to-back: write 0x03@0x7E, write 0x04@0x7D, read 0x7E, read 0x7D, with `req` held continuously → 4 acks on alternate cycles; reads return 0x03 then 0x04.
- Ignored request: assert `req` to write 0xFF@0x10 while `busy`=1 from a prior access, for that single cycle only → no extra `ack`; a later read of 0x10 returns its old value.
- Clear: preload 0x11@0x00 and 0x22@0x7F, pulse `clr` together with `req` → `req` is dropped, `busy` stays high 128 cycles, then one `ack`; reads of 0x00 and 0x7F both return 0x00.
- Reset mid-clear: fill all words with 0xAA, start a clear, assert `rst` when `cnt`=64 → no `ack`; addr 0x3F reads 0x00 and addr 0x40 reads 0xAA.
